// File: rtl/test_runner_pkg.sv
// ---------------------------------------------------------------------------
// test_runner_pkg: state encoding, LED colour triples and helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package test_runner_pkg;

  localparam logic [2:0] S_DELAY = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PASS  = 3'd2;
  localparam logic [2:0] S_FAIL  = 3'd3;
  localparam logic [2:0] S_TMO   = 3'd4;

  typedef enum logic [2:0] {
    ST_DELAY = S_DELAY,
    ST_RUN   = S_RUN,
    ST_PASS  = S_PASS,
    ST_FAIL  = S_FAIL,
    ST_TMO   = S_TMO
  } state_t;

  // Colour triples are {r,g,b}.
  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_GREEN = 3'b010;
  localparam logic [2:0] LED_RED   = 3'b100;
  localparam logic [2:0] LED_BLUE  = 3'b001;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/test_runner_led_if.sv
// ---------------------------------------------------------------------------
// test_runner_led_if: run/running/passed handshake to a self-test fixture. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface test_runner_led_if;
  logic run;
  logic running;
  logic passed;

  modport master (output run, input running, input passed);
  modport slave  (input run, output running, output passed);
endinterface

`default_nettype wire

// File: rtl/test_runner_led_blink_gen.sv
// ---------------------------------------------------------------------------
// blink_gen: free-running prescaler whose MSB is the LED blink phase. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blink_gen #(
  parameter int BLINK_LOG2 = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_blink
);

  logic [BLINK_LOG2-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_q + BLINK_LOG2'(1);
  end

  assign o_blink = cnt_q[BLINK_LOG2-1];

endmodule

`default_nettype wire

// File: rtl/test_runner_led.sv
// ---------------------------------------------------------------------------
// test_runner_led: runs one self-test fixture with a watchdog, shows verdict on RGB LED. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module test_runner_led
  import test_runner_pkg::*;
#(
  parameter int START_DELAY = 16,
  parameter int TIMEOUT     = 1024,
  parameter int BLINK_LOG2  = 22
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_restart,
  test_runner_led_if.master   fx,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_timeout,
  output logic                o_red,
  output logic                o_green,
  output logic                o_blue
);

  localparam int CNT_W = (max2(START_DELAY, TIMEOUT) > 1) ? $clog2(max2(START_DELAY, TIMEOUT)) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             tmo_q, tmo_d;
  logic [2:0]       led_q, led_d;
  logic             blink;

  blink_gen #(.BLINK_LOG2(BLINK_LOG2)) u_blink (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_blink (blink)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_DELAY;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      led_q   <= LED_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      run_q   <= run_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    run_d   = run_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
          run_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fx.running) seen_d = 1'b1;
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (seen_q && !fx.running) begin
          state_d = fx.passed ? ST_PASS : ST_FAIL;
          cnt_d   = '0;
          run_d   = 1'b0;
          done_d  = 1'b1;
          pass_d  = fx.passed;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_TMO;
          cnt_d   = '0;
          run_d   = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: begin
        if (i_restart) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
          seen_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = ST_DELAY;
    endcase
  end

  always_comb begin
    led_d = LED_OFF;
    case (state_q)
      ST_RUN:  led_d = blink ? LED_BLUE : LED_OFF;
      ST_PASS: led_d = LED_GREEN;
      ST_FAIL: led_d = blink ? LED_RED : LED_OFF;
      ST_TMO:  led_d = blink ? LED_RED : LED_BLUE;
      default: led_d = LED_OFF;
    endcase
  end

  assign fx.run    = run_q;
  assign o_done    = done_q;
  assign o_pass    = pass_q;
  assign o_timeout = tmo_q;
  assign o_red     = led_q[2];
  assign o_green   = led_q[1];
  assign o_blue    = led_q[0];

endmodule

`default_nettype wire

// File: tb/tb_test_runner_led.sv
// ---------------------------------------------------------------------------
// tb_test_runner_led: directed scoreboard bench for test_runner_led. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_test_runner_led;

  localparam int SD = 4;
  localparam int TO = 20;
  localparam int BL = 3;

  localparam int M_DELAY = 0;
  localparam int M_RUN   = 1;
  localparam int M_PASS  = 2;
  localparam int M_FAIL  = 3;
  localparam int M_TMO   = 4;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  logic o_done, o_pass, o_timeout, o_red, o_green, o_blue;
  logic [BL-1:0] bcnt;
  logic [6:0] obs;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  test_runner_led_if fx_if ();

  test_runner_led #(
    .START_DELAY (SD),
    .TIMEOUT     (TO),
    .BLINK_LOG2  (BL)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_restart (restart),
    .fx        (fx_if),
    .o_done    (o_done),
    .o_pass    (o_pass),
    .o_timeout (o_timeout),
    .o_red     (o_red),
    .o_green   (o_green),
    .o_blue    (o_blue)
  );

  always #5 clk = ~clk;

  // Reference blink prescaler: LED outputs after an edge follow bcnt's MSB before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= '0;
    else        bcnt <= bcnt + 3'd1;
  end

  assign obs = {fx_if.run, o_done, o_pass, o_timeout, o_red, o_green, o_blue};

  function automatic logic [2:0] led_for(input int mode);
    logic b;
    b = bcnt[BL-1];
    case (mode)
      M_RUN:   return {1'b0, 1'b0, b};
      M_PASS:  return 3'b010;
      M_FAIL:  return {b, 1'b0, 1'b0};
      M_TMO:   return {b, 1'b0, ~b};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] mk(input logic run, input logic done, input logic pass,
                                    input logic tmo, input logic [2:0] led);
    return {run, done, pass, tmo, led};
  endfunction

  task automatic push(input string tag, input logic [6:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b (run,done,pass,tmo,r,g,b)", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [6:0] exp);
    push(tag, exp);
    tick();
    check_out();
  endtask

  task automatic delay_phase();
    for (int k = 1; k <= SD; k++)
      step("delay", mk(k == SD, 1'b0, 1'b0, 1'b0, 3'b000));
  endtask

  task automatic restart_from(input int mode);
    restart = 1'b1;
    step("restart_clear", mk(1'b0, 1'b0, 1'b0, 1'b0, led_for(mode)));
    restart = 1'b0;
    delay_phase();
  endtask

  task automatic run_fixture(input int n, input logic p);
    fx_if.running = 1'b1;
    fx_if.passed  = p;
    for (int k = 1; k <= n; k++)
      step("running", mk(1'b1, 1'b0, 1'b0, 1'b0, led_for(M_RUN)));
    fx_if.running = 1'b0;
    step("verdict", mk(1'b0, 1'b1, p, 1'b0, led_for(M_RUN)));
    for (int k = 1; k <= 10; k++)
      step(p ? "pass_led" : "fail_led", mk(1'b0, 1'b1, p, 1'b0, led_for(p ? M_PASS : M_FAIL)));
  endtask

  task automatic watch_timeout();
    for (int k = 1; k < TO; k++)
      step("watchdog_run", mk(1'b1, 1'b0, 1'b0, 1'b0, led_for(M_RUN)));
    step("timeout", mk(1'b0, 1'b1, 1'b0, 1'b1, led_for(M_RUN)));
    for (int k = 1; k <= 10; k++)
      step("tmo_led", mk(1'b0, 1'b1, 1'b0, 1'b1, led_for(M_TMO)));
  endtask

  initial begin
    rst_n         = 1'b0;
    restart       = 1'b0;
    fx_if.running = 1'b0;
    fx_if.passed  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push("reset_state", 7'b0);
    check_out();

    // Start-up delay, then a passing fixture run.
    rst_n = 1'b1;
    delay_phase();
    run_fixture(6, 1'b1);

    // Failing fixture run.
    restart_from(M_PASS);
    run_fixture(6, 1'b0);

    // Fixture stuck running: watchdog fires.
    restart_from(M_FAIL);
    fx_if.running = 1'b1;
    watch_timeout();

    // Completion on the terminal watchdog cycle, with a restart pulse ignored mid-run.
    restart_from(M_TMO);
    fx_if.running = 1'b1;
    fx_if.passed  = 1'b1;
    for (int k = 1; k < TO; k++) begin
      restart = (k == 5);
      step("edge_run", mk(1'b1, 1'b0, 1'b0, 1'b0, led_for(M_RUN)));
    end
    restart = 1'b0;
    fx_if.running = 1'b0;
    step("edge_verdict", mk(1'b0, 1'b1, 1'b1, 1'b0, led_for(M_RUN)));
    step("edge_pass_led", mk(1'b0, 1'b1, 1'b1, 1'b0, led_for(M_PASS)));

    // Asynchronous reset in the middle of a run.
    restart_from(M_PASS);
    fx_if.running = 1'b1;
    for (int k = 1; k <= 3; k++)
      step("pre_reset_run", mk(1'b1, 1'b0, 1'b0, 1'b0, led_for(M_RUN)));
    #3;
    rst_n = 1'b0;
    #1;
    push("async_reset", 7'b0);
    check_out();
    @(posedge clk);
    #1;
    push("held_reset", 7'b0);
    check_out();
    rst_n = 1'b1;
    fx_if.running = 1'b0;
    delay_phase();

    // Fixture never starts: a low i_running is not completion.
    watch_timeout();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
